// File: rtl/flash_ctrl.sv
// flash_ctrl
//   Read-only responder for the shared mem_* port, backed by the DE2-70
//   parallel NOR flash in 16-bit word mode. Each 32-bit word is built from
//   two half-word flash reads. The even half-word supplies bits [31:16] and
//   the odd half-word supplies bits [15:0], which gives big-endian order.
//   Writes are accepted and then dropped.
//
// Parameters
//   WAIT_CYCLES  cycles that address/OE are held per half-word (1..255)
//   BOOT_CYCLES  cycles after reset release before the first request (1..65535)
//
// Ports
//   clock, reset             single clock, synchronous active-high reset
//   mem_waitrequest          high = request not accepted this cycle
//   mem_id                   requester tag (0 never used by requesters)
//   mem_address              word address, bits [20:0] used
//   mem_read / mem_write     request strobes (write is discarded)
//   mem_writedata/mask       ignored
//   mem_readdata             returned word, holds between responses
//   mem_readdataid           tag of returned word, 0 = no data
//   oFLASH_A                 flash half-word address
//   FLASH_DQ, FLASH_DQ15_AM1 flash data bus, never driven by this block
//   oFLASH_CE_N/OE_N         low during half-word reads (registered)
//   oFLASH_WE_N/WP_N/BYTE_N  tied high
//   oFLASH_RST_N             registered ~reset
//   iFLASH_RY_N              ignored
module flash_ctrl #(
   parameter int unsigned WAIT_CYCLES = 6,
   parameter int unsigned BOOT_CYCLES = 1000
) (
   input  logic        clock,
   input  logic        reset,
   output logic        mem_waitrequest,
   input  logic [1:0]  mem_id,
   input  logic [29:0] mem_address,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] mem_writedata,
   input  logic [3:0]  mem_writedatamask,
   output logic [31:0] mem_readdata,
   output logic [1:0]  mem_readdataid,
   output logic [21:0] oFLASH_A,
   inout  logic [14:0] FLASH_DQ,
   inout  logic        FLASH_DQ15_AM1,
   output logic        oFLASH_CE_N,
   output logic        oFLASH_OE_N,
   output logic        oFLASH_WE_N,
   output logic        oFLASH_WP_N,
   output logic        oFLASH_BYTE_N,
   output logic        oFLASH_RST_N,
   input  logic        iFLASH_RY_N
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      IDLE  = 2'd1,
      RD_LO = 2'd2,
      RD_HI = 2'd3
   } state_t;

   localparam logic [15:0] BOOT_LOAD = 16'(BOOT_CYCLES - 1);
   localparam logic [15:0] WAIT_LOAD = 16'(WAIT_CYCLES - 1);

   state_t      state, state_next;
   logic [15:0] cnt, cnt_next;
   logic        cnt_zero;
   logic        start_read;
   logic        capture_lo;
   logic        respond;
   logic        strobe_n_next;
   logic [20:0] addr_q;
   logic [1:0]  id_q;
   logic [15:0] data_lo;
   logic [15:0] flash_data;
   logic        rst_n_q;

   // Inputs with no function in a read-only responder.
   logic unused_ok;
   assign unused_ok = ^{mem_writedata, mem_writedatamask, iFLASH_RY_N,
                        mem_address[29:21]};

   // The flash bus is only ever sampled; the block never drives it.
   assign flash_data = {FLASH_DQ15_AM1, FLASH_DQ};

   assign mem_waitrequest = reset | (state != IDLE);
   assign cnt_zero        = (cnt == '0);

   assign oFLASH_WE_N   = 1'b1;
   assign oFLASH_WP_N   = 1'b1;
   assign oFLASH_BYTE_N = 1'b1;
   assign oFLASH_RST_N  = rst_n_q;

   always_ff @(posedge clock) begin
      if (reset)
         state <= BOOT;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      start_read = 1'b0;
      capture_lo = 1'b0;
      respond    = 1'b0;
      case (state)
         BOOT: begin
            if (cnt_zero)
               state_next = IDLE;
            else
               cnt_next = cnt - 16'd1;
         end
         IDLE: begin
            // Read+write together counts as a read; a lone write is
            // accepted here and has no further effect.
            if (mem_read) begin
               start_read = 1'b1;
               state_next = RD_LO;
               cnt_next   = WAIT_LOAD;
            end
         end
         RD_LO: begin
            if (cnt_zero) begin
               capture_lo = 1'b1;
               state_next = RD_HI;
               cnt_next   = WAIT_LOAD;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end
         RD_HI: begin
            if (cnt_zero) begin
               respond    = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - 16'd1;
            end
         end
         default: state_next = BOOT;
      endcase
      // Strobes are registered from the next state so they track the
      // read phases cycle-for-cycle.
      strobe_n_next = !((state_next == RD_LO) || (state_next == RD_HI));
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt            <= BOOT_LOAD;
         addr_q         <= '0;
         id_q           <= '0;
         data_lo        <= '0;
         mem_readdata   <= '0;
         mem_readdataid <= '0;
         oFLASH_A       <= '0;
         oFLASH_CE_N    <= 1'b1;
         oFLASH_OE_N    <= 1'b1;
      end else begin
         cnt            <= cnt_next;
         oFLASH_CE_N    <= strobe_n_next;
         oFLASH_OE_N    <= strobe_n_next;
         mem_readdataid <= '0;
         if (start_read) begin
            addr_q   <= mem_address[20:0];
            id_q     <= mem_id;
            oFLASH_A <= {mem_address[20:0], 1'b0};
         end
         if (capture_lo) begin
            data_lo  <= flash_data;
            oFLASH_A <= {addr_q, 1'b1};
         end
         if (respond) begin
            mem_readdata   <= {data_lo, flash_data};
            mem_readdataid <= id_q;
         end
      end
   end

   always_ff @(posedge clock) begin
      rst_n_q <= ~reset;
   end

endmodule

// File: doc/flash_ctrl.md
# flash_ctrl

Read-only responder for the shared `mem_*` memory port. It serves CPU or boot-loader reads from the DE2-70 parallel NOR flash, which runs in 16-bit word mode. Each 32-bit word is assembled from two half-word flash reads, with a configurable number of wait states per half-word. The block sits beside `ssram_ctrl` in the same address-decoded memory fabric and speaks the same waitrequest/readdataid protocol. Flash programming is out of scope: writes are accepted and discarded.

## Interface
Parameters:
- `WAIT_CYCLES`, 6 — clock cycles that address/OE are held per half-word read. Legal range 1..255. 6 gives 120 ns at 50 MHz.
- `BOOT_CYCLES`, 1000 — cycles after reset release before the first request is accepted (flash RST recovery). Legal range 1..65535.

Ports:
- `clock`  in  1  single clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `mem_waitrequest`  out  1  high = request not accepted this cycle.
- `mem_id`  in  2  requester tag; 0 is never used by requesters.
- `mem_address`  in  30  32-bit word address; bits [20:0] are used, the rest are ignored.
- `mem_read`  in  1  read request.
- `mem_write`  in  1  write request (discarded).
- `mem_writedata`  in  32  ignored.
- `mem_writedatamask`  in  4  ignored.
- `mem_readdata`  out  32  returned word; valid only while `mem_readdataid` != 0.
- `mem_readdataid`  out  2  tag of the returned word; 0 = no data this cycle.
- `oFLASH_A`  out  22  flash half-word address.
- `FLASH_DQ`  inout  15  flash data [14:0]; always tri-stated (input only).
- `FLASH_DQ15_AM1`  inout  1  flash data bit 15 in word mode; always tri-stated.
- `oFLASH_CE_N`, `oFLASH_OE_N`  out  1  low during a half-word read.
- `oFLASH_WE_N`  out  1  constant 1.
- `oFLASH_WP_N`  out  1  constant 1.
- `oFLASH_BYTE_N`  out  1  constant 1 (word mode).
- `oFLASH_RST_N`  out  1  equals registered ~reset.
- `iFLASH_RY_N`  in  1  ignored (read-only block).

## Operation
- A request is accepted at a rising edge where (`mem_read` | `mem_write`) & !`mem_waitrequest`.
- At acceptance the block registers `mem_address[20:0]` and `mem_id`.
- `mem_read` and `mem_write` both high is treated as a read.
- Accepted write: no state change, no response. The block stays in IDLE and can accept another request on the next cycle.
- `mem_waitrequest` = `reset` | (state != IDLE). It is combinational from the state register.
- States and transitions:
  - BOOT: entered on reset. A counter counts `BOOT_CYCLES`, then the state goes to IDLE.
  - IDLE: an accepted read goes to RD_LO.
  - RD_LO: the counter counts `WAIT_CYCLES`; on expiry the low data is captured and the state goes to RD_HI.
  - RD_HI: the counter counts `WAIT_CYCLES`; on expiry the state goes to IDLE and the response is issued.
- Address mapping: `oFLASH_A` = {addr[20:0], 0} in RD_LO and {addr[20:0], 1} in RD_HI.
- Byte order is big-endian, matching the CPU. The half-word at the even address goes to `mem_readdata[31:16]`; the half-word at the odd address goes to `[15:0]`.
- Flash data {`FLASH_DQ15_AM1`, `FLASH_DQ`} is sampled into the data register at the last edge of each RD_* phase.
- `mem_readdataid` equals the registered id for exactly one cycle after RD_HI ends, and is 0 otherwise.
- `mem_readdata` holds its last value between responses.
- `oFLASH_CE_N` and `oFLASH_OE_N` are registered. They are low throughout RD_LO and RD_HI, and high in BOOT and IDLE.
- Reset mid-read: the read is abandoned with no response. The state goes to BOOT, `mem_readdataid` goes to 0 and the flash strobes go high.

## Timing
- Reset values: state BOOT; `mem_waitrequest` 1; `mem_readdataid` 0; `mem_readdata` 0; `oFLASH_A` 0; `oFLASH_CE_N` 1; `oFLASH_OE_N` 1; `oFLASH_RST_N` 0.
- After `reset` falls, `oFLASH_RST_N` is 1 from the next cycle.
- `mem_waitrequest` falls after exactly `BOOT_CYCLES` cycles of BOOT.
- Read accepted at edge 0:
  - cycles 1..W carry the even address with CE/OE low; the low half-word is sampled at edge W;
  - cycles W+1..2W carry the odd address; the high half-word is sampled at edge 2W;
  - cycle 2W+1 has `mem_readdataid` = id, valid `mem_readdata`, and `mem_waitrequest` = 0.
- A new request may be accepted at edge 2W+1, so throughput is one read per 2W+1 cycles.
- Back-to-back reads keep CE/OE low continuously except for the single IDLE cycle.
- An accepted write costs 1 cycle; a read presented the following cycle is accepted immediately.

## Test plan
- Boot hold: W=3, BOOT_CYCLES=4, assert reset for 2 cycles, then release → `mem_waitrequest`=1 for exactly 4 cycles after release; `oFLASH_RST_N`=1 from the first cycle after release.
- Single read: W=3, `mem_address`=0x123, id=2; flash model returns 0xBEEF at 0x246 and 0x1234 at 0x247 → `oFLASH_A`=0x246 in cycles 1-3 and 0x247 in cycles 4-6; cycle 7 shows `mem_readdata`=0xBEEF1234 and `mem_readdataid`=2 for one cycle only.
- Back-to-back reads: id 1 at address 0, then id 3 at address 0x1FFFFF (top of flash) held pending → second request accepted at edge 7; `oFLASH_A`=0x3FFFFE then 0x3FFFFF; both responses appear with the correct tags and data.
- Write discard: write to 0x10 with data 0xFFFFFFFF, then read 0x10 → write accepted in 1 cycle with no `mem_readdataid` pulse; `oFLASH_WE_N` stays 1; the read returns the model's original contents.
- Reset mid-read: assert reset in cycle 4 of a W=3 read → no `mem_readdataid` pulse ever appears; CE_N/OE_N=1 next cycle; BOOT hold is repeated.
- Address aliasing: read `mem_address`=0x3FE00005 → `oFLASH_A`=0x00000A/0x00000B (bits 29:21 ignored).
